seven_seg_scanner: RTL and testbench

//   Time-multiplexed 4-digit seven-segment driver for Basys3; consumes 4-bit BCD digits (DataOut of a SingleBCD chain).

---
 rtl/seven_seg_scanner_if.sv | 13 +
 rtl/seven_seg_scanner.sv | 98 +++++++++
 tb/tb_seven_seg_scanner.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/seven_seg_scanner_if.sv
// Pin bundle between the BCD counter chain / board pins and the seven-segment scanner.
// Master drives the digit data and enable; slave (the scanner) drives Seg/An/Dp.
interface seven_seg_scanner_if;
    logic        Enable;
    logic [15:0] DataIn;
    logic [3:0]  DpIn;
    logic [6:0]  Seg;
    logic [3:0]  An;
    logic        Dp;

    modport master (output Enable, DataIn, DpIn, input Seg, An, Dp);
    modport slave  (input Enable, DataIn, DpIn, output Seg, An, Dp);
endinterface

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed 4-digit seven-segment driver with registered, active-low outputs.
// Optional leading-zero blanking of digits 3..1 when LEADING_ZERO_BLANK_EN is defined.
module seven_seg_scanner #(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned DIV_WIDTH   = 17
) (
    input logic                 Clk,
    input logic                 Reset,
    seven_seg_scanner_if.slave  bus
);

    logic [DIV_WIDTH-1:0] pre_cnt_q, pre_cnt_d;
    logic [1:0]           sel_q, sel_d;
    logic [3:0]           an_q, an_d;
    logic [6:0]           seg_q, seg_d;
    logic                 dp_q, dp_d;
    logic [3:0]           nib;
    logic                 blank;

    function automatic logic [6:0] decode(input logic [3:0] d);
        unique case (d)
            4'd0:    decode = 7'b1000000;
            4'd1:    decode = 7'b1111001;
            4'd2:    decode = 7'b0100100;
            4'd3:    decode = 7'b0110000;
            4'd4:    decode = 7'b0011001;
            4'd5:    decode = 7'b0010010;
            4'd6:    decode = 7'b0000010;
            4'd7:    decode = 7'b1111000;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0010000;
            default: decode = 7'b0111111;
        endcase
    endfunction

    always_comb begin
        unique case (sel_q)
            2'd0:    nib = bus.DataIn[3:0];
            2'd1:    nib = bus.DataIn[7:4];
            2'd2:    nib = bus.DataIn[11:8];
            default: nib = bus.DataIn[15:12];
        endcase
    end

`ifdef LEADING_ZERO_BLANK_EN
    // lead_zero[i]: digit i and every digit above it are zero; digit0 is never blanked.
    logic [3:0] lead_zero;
    always_comb begin
        lead_zero[3] = (bus.DataIn[15:12] == 4'h0);
        lead_zero[2] = lead_zero[3] && (bus.DataIn[11:8] == 4'h0);
        lead_zero[1] = lead_zero[2] && (bus.DataIn[7:4] == 4'h0);
        lead_zero[0] = 1'b0;
        blank        = lead_zero[sel_q];
    end
`else
    assign blank = 1'b0;
`endif

    always_comb begin
        pre_cnt_d = pre_cnt_q;
        sel_d     = sel_q;
        an_d      = 4'b1111;
        seg_d     = 7'b1111111;
        dp_d      = 1'b1;
        if (bus.Enable) begin
            if (pre_cnt_q == DIV_WIDTH'(REFRESH_DIV - 1)) begin
                pre_cnt_d = '0;
                sel_d     = sel_q + 2'd1;
            end else begin
                pre_cnt_d = pre_cnt_q + DIV_WIDTH'(1);
            end
            an_d  = ~(4'b0001 << sel_q);
            seg_d = blank ? 7'b1111111 : decode(nib);
            dp_d  = ~bus.DpIn[sel_q];
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            pre_cnt_q <= '0;
            sel_q     <= 2'd0;
            an_q      <= 4'b1111;
            seg_q     <= 7'b1111111;
            dp_q      <= 1'b1;
        end else begin
            pre_cnt_q <= pre_cnt_d;
            sel_q     <= sel_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
        end
    end

    assign bus.An  = an_q;
    assign bus.Seg = seg_q;
    assign bus.Dp  = dp_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner with a cycle-level scoreboard (REFRESH_DIV=4).
// Expectations follow LEADING_ZERO_BLANK_EN when it is defined.
module tb_seven_seg_scanner;

    localparam int unsigned Div = 4;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    logic Clk;
    logic rst_n;
    seven_seg_scanner_if bus ();

    seven_seg_scanner #(.REFRESH_DIV(Div), .DIV_WIDTH(2)) dut (
        .Clk   (Clk),
        .Reset (rst_n),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    exp_t       exp_q[$];
    int         n_assert = 0;
    int         n_fail   = 0;
    int         m_pre    = 0;
    int         m_sel    = 0;
    logic [3:0] obs_an;
    logic [6:0] obs_seg;
    logic       obs_dp;
    logic [6:0] seen_seg[4];
    logic       seen_dp[4];

    function automatic logic [6:0] ref_seg(input logic [3:0] d);
        case (d)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // One clock: predict from current inputs, advance the model, then compare after the edge.
    task automatic tick();
        exp_t        e;
        logic [15:0] upper;
        if (bus.Enable) begin
            e.an  = ~(4'b0001 << m_sel);
            e.seg = ref_seg(4'(bus.DataIn >> (4 * m_sel)));
            e.dp  = ~bus.DpIn[m_sel];
`ifdef LEADING_ZERO_BLANK_EN
            upper = bus.DataIn >> (4 * m_sel);
            if (m_sel != 0 && upper == 16'h0) e.seg = 7'b1111111;
`else
            upper = 16'h0;
`endif
            m_pre++;
            if (m_pre == Div) begin
                m_pre = 0;
                m_sel = (m_sel + 1) % 4;
            end
        end else begin
            e = '{an: 4'b1111, seg: 7'b1111111, dp: 1'b1};
        end
        exp_q.push_back(e);
        @(posedge Clk);
        #1;
        e       = exp_q.pop_front();
        obs_an  = bus.An;
        obs_seg = bus.Seg;
        obs_dp  = bus.Dp;
        chk("an", {3'b000, obs_an}, {3'b000, e.an});
        chk("seg", obs_seg, e.seg);
        chk("dp", {6'b0, obs_dp}, {6'b0, e.dp});
        for (int i = 0; i < 4; i++) begin
            if (obs_an == ~(4'b0001 << i)) begin
                seen_seg[i] = obs_seg;
                seen_dp[i]  = obs_dp;
            end
        end
    endtask

    task automatic chk_dark(input string tag);
        chk({tag, "_an"}, {3'b000, bus.An}, 7'b0001111);
        chk({tag, "_seg"}, bus.Seg, 7'b1111111);
        chk({tag, "_dp"}, {6'b0, bus.Dp}, 7'b0000001);
    endtask

    initial begin
        rst_n      = 1'b0;
        bus.Enable = 1'b0;
        bus.DataIn = 16'h0;
        bus.DpIn   = 4'h0;

        // Reset held for 3 cycles
        repeat (3) @(posedge Clk);
        #1;
        chk_dark("reset");

        // Scan 16'h1234: first edge lights digit0, then full rotation plus wrap
        rst_n      = 1'b1;
        bus.Enable = 1'b1;
        bus.DataIn = 16'h1234;
        bus.DpIn   = 4'b0000;
        tick();
        chk("first_an", {3'b000, obs_an}, 7'b0001110);
        chk("first_seg", obs_seg, 7'b0011001);
        repeat (19) tick();
        chk("wrap_an", {3'b000, obs_an}, 7'b0001110);
        chk("d0_seg", seen_seg[0], 7'b0011001);
        chk("d1_seg", seen_seg[1], 7'b0110000);
        chk("d2_seg", seen_seg[2], 7'b0100100);
        chk("d3_seg", seen_seg[3], 7'b1111001);

        // Invalid nibble on digit1 shows a dash; its decimal point lit alone
        bus.DataIn = 16'h12A4;
        bus.DpIn   = 4'b0010;
        repeat (16) tick();
        chk("dash_seg", seen_seg[1], 7'b0111111);
        chk("dash_dp", {6'b0, seen_dp[1]}, 7'b0000000);
        chk("d0_dp", {6'b0, seen_dp[0]}, 7'b0000001);

        // Disable during digit2 with one cycle already shown
        bus.DataIn = 16'h1234;
        bus.DpIn   = 4'b0000;
        for (int k = 0; k < 32; k++) begin
            if (m_sel == 2 && m_pre == 1) break;
            tick();
        end
        bus.Enable = 1'b0;
        tick();
        chk("dis_an", {3'b000, obs_an}, 7'b0001111);
        repeat (9) tick();
        bus.Enable = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("resume_an", {3'b000, obs_an}, 7'b0001011);
        end
        tick();
        chk("next_an", {3'b000, obs_an}, 7'b0000111);

        // Asynchronous reset between edges
        repeat (5) tick();
        @(negedge Clk);
        rst_n = 1'b0;
        #1;
        chk_dark("async_rst");
        @(posedge Clk);
        #1;
        chk_dark("rst_held");
        @(negedge Clk);
        rst_n = 1'b1;
        m_pre = 0;
        m_sel = 0;
        tick();
        chk("restart_an", {3'b000, obs_an}, 7'b0001110);

        // Leading zeros
        bus.DataIn = 16'h0050;
        bus.DpIn   = 4'b0000;
        repeat (16) tick();
`ifdef LEADING_ZERO_BLANK_EN
        chk("lz_d3", seen_seg[3], 7'b1111111);
        chk("lz_d2", seen_seg[2], 7'b1111111);
`else
        chk("lz_d3", seen_seg[3], 7'b1000000);
        chk("lz_d2", seen_seg[2], 7'b1000000);
`endif
        chk("lz_d1", seen_seg[1], 7'b0010010);
        chk("lz_d0", seen_seg[0], 7'b1000000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
